// File: rtl/cpu_ctl_fsm.sv
// Multi-cycle instruction sequencer: fetch handshake, opcode classification,
// and EXEC/MEM/WB stepping with a retired-instruction counter.
module cpu_ctl_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clka,
   input  logic             reset_in,
   input  logic             run_in,
   input  logic [3:0]       opcode_in,
   input  logic             mem_ready_in,
   input  logic             branch_taken_in,
   output logic [2:0]       state_out,
   output logic             mem_req_out,
   output logic             mem_we_out,
   output logic             ir_we_out,
   output logic             pc_we_out,
   output logic [1:0]       pc_sel_out,
   output logic             reg_src_out,
   output logic             we_reg_out,
   output logic             br_out,
   output logic [CNT_W-1:0] instr_count_out
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_STORE, C_BR, C_JMP, C_TRAP, C_NOP
   } cls_t;

   state_t            state_q, state_d;
   cls_t              cls_q, cls_d, op_cls;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              retire;

   always_comb begin
      case (opcode_in)
         4'b0001, 4'b0101, 4'b1001: op_cls = C_ALU;
         4'b0010, 4'b0110:          op_cls = C_LOAD;
         4'b0011, 4'b0111:          op_cls = C_STORE;
         4'b0000:                   op_cls = C_BR;
         4'b1100:                   op_cls = C_JMP;
         4'b1111:                   op_cls = C_TRAP;
         default:                   op_cls = C_NOP;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      cnt_d       = cnt_q;
      retire      = 1'b0;
      mem_req_out = 1'b0;
      mem_we_out  = 1'b0;
      ir_we_out   = 1'b0;
      pc_we_out   = 1'b0;
      pc_sel_out  = 2'b00;
      reg_src_out = 1'b0;
      we_reg_out  = 1'b0;
      br_out      = 1'b0;

      case (state_q)
         S_IDLE: if (run_in) state_d = S_FETCH;
         S_FETCH: begin
            mem_req_out = 1'b1;
            if (mem_ready_in) begin
               ir_we_out = 1'b1;
               pc_we_out = 1'b1;
               state_d   = S_DECODE;
            end
         end
         // The class register is not loaded yet, so DECODE looks at the raw opcode.
         S_DECODE: begin
            cls_d  = op_cls;
            br_out = (op_cls == C_BR);
            case (op_cls)
               C_TRAP:  state_d = S_HALT;
               C_NOP:   retire  = 1'b1;
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_ALU:           state_d = S_WB;
               C_LOAD, C_STORE: state_d = S_MEM;
               C_BR: begin
                  br_out = 1'b1;
                  if (branch_taken_in) begin
                     pc_we_out  = 1'b1;
                     pc_sel_out = 2'b01;
                  end
                  retire = 1'b1;
               end
               C_JMP: begin
                  pc_we_out  = 1'b1;
                  pc_sel_out = 2'b10;
                  retire     = 1'b1;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_MEM: begin
            mem_req_out = 1'b1;
            mem_we_out  = (cls_q == C_STORE);
            if (mem_ready_in) begin
               if (cls_q == C_STORE) retire  = 1'b1;
               else                  state_d = S_WB;
            end
         end
         S_WB: begin
            we_reg_out  = 1'b1;
            reg_src_out = (cls_q == C_LOAD);
            retire      = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         cnt_d   = cnt_q + 1'b1;
         state_d = run_in ? S_FETCH : S_IDLE;
      end
   end

   always_ff @(posedge clka) begin
      if (reset_in) begin
         state_q <= S_IDLE;
         cls_q   <= C_NOP;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_out       = state_q;
   assign instr_count_out = cnt_q;

endmodule
